// File: rtl/pipeline_mem_stage.sv
// Memory-access stage of the RV64 pipeline: req/ack data-memory bus, load extension, WB registers.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module pipeline_mem_stage #(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       alu_result_EX,
    input  logic [63:0]       reg_data2_MEM,
    input  logic [4:0]        rd_MEM,
    input  logic [63:0]       pc_out,
    input  logic [2:0]        dm_rd_ctrl_EX,
    input  logic [1:0]        dm_wr_ctrl_EX,
    input  logic              dm_wr_dw_EX,
    input  logic              reg_wr_en_MEM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [63:0]       dmem_wdata,
    output logic [7:0]        dmem_wstrb,
    input  logic              dmem_ack,
    input  logic [63:0]       dmem_rdata,
    output logic              stall_MEM,
    output logic [63:0]       wb_data_WB,
    output logic [4:0]        rd_WB,
    output logic              reg_wr_WB,
    output logic [63:0]       pc_WB,
    output logic              misalign_WB
);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e              state_q;
    logic                req_q, we_q, wen_q, reg_wr_q, misalign_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [63:0]         wdata_q, pc_q, wb_data_q, pc_wb_q;
    logic [7:0]          wstrb_q;
    logic [2:0]          ld_ctrl_q, off_q;
    logic [4:0]          rd_q, rd_wb_q;

    logic                is_load, is_store, mem_op, trap;
    logic [2:0]          off;
    logic [1:0]          size;   // 0 byte, 1 half, 2 word, 3 doubleword
    logic [7:0]          lane_mask, strb;
    logic [63:0]         wdata, ld_shift, ld_data;
    logic [ADDR_W-1:0]   addr_al;

    always_comb begin
        is_load  = |dm_rd_ctrl_EX;
        is_store = !is_load && (|dm_wr_ctrl_EX);
        mem_op   = is_load || is_store;
        off      = alu_result_EX[2:0];
        addr_al  = {alu_result_EX[ADDR_W-1:3], 3'b000};

        size = 2'd0;
        if (is_load) begin
            case (dm_rd_ctrl_EX)
                3'b001, 3'b010: size = 2'd0;
                3'b011, 3'b100: size = 2'd1;
                3'b101, 3'b110: size = 2'd2;
                default:        size = 2'd3;
            endcase
        end else begin
            case (dm_wr_ctrl_EX)
                2'b01:   size = 2'd0;
                2'b10:   size = 2'd1;
                default: size = dm_wr_dw_EX ? 2'd3 : 2'd2;
            endcase
        end

        lane_mask = 8'h01;
        wdata     = {8{reg_data2_MEM[7:0]}};
        case (size)
            2'd1: begin
                lane_mask = 8'h03;
                wdata     = {4{reg_data2_MEM[15:0]}};
            end
            2'd2: begin
                lane_mask = 8'h0F;
                wdata     = {2{reg_data2_MEM[31:0]}};
            end
            2'd3: begin
                lane_mask = 8'hFF;
                wdata     = reg_data2_MEM;
            end
            default: ;
        endcase
        // Doublewords always enable every lane; narrower lanes shifted past bit 7 are lost.
        strb = (size == 2'd3) ? 8'hFF : (lane_mask << off);

`ifdef MEM_MISALIGN_TRAP_EN
        trap = mem_op && (((size == 2'd1) && off[0]) ||
                          ((size == 2'd2) && (off[1:0] != 2'b00)) ||
                          ((size == 2'd3) && (off != 3'b000)));
`else
        trap = 1'b0;
`endif
    end

    always_comb begin
        ld_shift = dmem_rdata >> {off_q, 3'b000};
        case (ld_ctrl_q)
            3'b001:  ld_data = {{56{ld_shift[7]}}, ld_shift[7:0]};
            3'b010:  ld_data = {56'd0, ld_shift[7:0]};
            3'b011:  ld_data = {{48{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {48'd0, ld_shift[15:0]};
            3'b101:  ld_data = {{32{ld_shift[31]}}, ld_shift[31:0]};
            3'b110:  ld_data = {32'd0, ld_shift[31:0]};
            default: ld_data = ld_shift;
        endcase
    end

    always_comb begin
        if (state_q == StIdle) stall_MEM = mem_op && !trap;
        else                   stall_MEM = !dmem_ack;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            ld_ctrl_q  <= '0;
            off_q      <= '0;
            rd_q       <= '0;
            pc_q       <= '0;
            wen_q      <= 1'b0;
            wb_data_q  <= '0;
            rd_wb_q    <= '0;
            reg_wr_q   <= 1'b0;
            pc_wb_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mem_op && !trap) begin
                        state_q    <= StAccess;
                        req_q      <= 1'b1;
                        we_q       <= is_store;
                        addr_q     <= addr_al;
                        wdata_q    <= wdata;
                        wstrb_q    <= strb;
                        ld_ctrl_q  <= dm_rd_ctrl_EX;
                        off_q      <= off;
                        rd_q       <= rd_MEM;
                        pc_q       <= pc_out;
                        wen_q      <= reg_wr_en_MEM;
                        reg_wr_q   <= 1'b0;
                        misalign_q <= 1'b0;
                    end else begin
                        wb_data_q  <= alu_result_EX;
                        rd_wb_q    <= rd_MEM;
                        pc_wb_q    <= pc_out;
                        reg_wr_q   <= !trap && reg_wr_en_MEM && (rd_MEM != 5'd0);
                        misalign_q <= trap;
                    end
                end
                StAccess: begin
                    if (dmem_ack) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                        rd_wb_q <= rd_q;
                        pc_wb_q <= pc_q;
                        if (ld_ctrl_q != 3'b000) begin
                            wb_data_q <= ld_data;
                            reg_wr_q  <= wen_q && (rd_q != 5'd0);
                        end else begin
                            reg_wr_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign dmem_wstrb  = wstrb_q;
    assign wb_data_WB  = wb_data_q;
    assign rd_WB       = rd_wb_q;
    assign reg_wr_WB   = reg_wr_q;
    assign pc_WB       = pc_wb_q;
    assign misalign_WB = misalign_q;

endmodule
